mem_cmd_rr_arbiter: RTL and testbench

// - Merges NUM_CHANNELS memory-command streams (address/length, axis_mem_cmd style) onto one memory port.
// - Uses a round-robin arbiter and a single-entry registered output stage.
// - Records the source channel of every issued command in an in-order tag FIFO.
// - Routes each returned status word (axis_mem_status style) back to the channel that issued the command.
// - Sits between per-channel DMA/DDR clients and a shared datamover or DDR controller port.

---
 rtl/mem_cmd_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_cmd_rr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_rr_arbiter.sv
// Round-robin merge of NUM_CHANNELS memory-command streams onto one port.
// Every issued command pushes its source channel into an in-order tag FIFO.
// Returned status words are routed back to the channel at the FIFO head.
// Ports:
//   aclk, areset                 clock, async active-high reset
//   s_cmd_valid/ready/address/length   per-channel command inputs (packed per channel)
//   m_cmd_valid/ready/address/length   merged command output, single registered stage
//   s_sts_valid/ready/data       status from the memory port
//   m_sts_valid/ready/data       per-channel routed status (data replicated per slot)
//   inflight                     tag FIFO occupancy
//   sts_orphan                   sticky flag: status seen while no command was outstanding
module mem_cmd_rr_arbiter #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned LEN_WIDTH    = 32,
    parameter int unsigned STS_WIDTH    = 8,
    parameter int unsigned TAG_DEPTH    = 8
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [NUM_CHANNELS-1:0]           s_cmd_valid,
    output logic [NUM_CHANNELS-1:0]           s_cmd_ready,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] s_cmd_address,
    input  logic [NUM_CHANNELS*LEN_WIDTH-1:0] s_cmd_length,
    output logic                              m_cmd_valid,
    input  logic                              m_cmd_ready,
    output logic [ADDR_WIDTH-1:0]             m_cmd_address,
    output logic [LEN_WIDTH-1:0]              m_cmd_length,
    input  logic                              s_sts_valid,
    output logic                              s_sts_ready,
    input  logic [STS_WIDTH-1:0]              s_sts_data,
    output logic [NUM_CHANNELS-1:0]           m_sts_valid,
    input  logic [NUM_CHANNELS-1:0]           m_sts_ready,
    output logic [NUM_CHANNELS*STS_WIDTH-1:0] m_sts_data,
    output logic [$clog2(TAG_DEPTH+1)-1:0]    inflight,
    output logic                              sts_orphan
);

    localparam int unsigned CH_W  = $clog2(NUM_CHANNELS);
    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);

    logic                  m_cmd_valid_q, m_cmd_valid_d;
    logic [ADDR_WIDTH-1:0] m_cmd_address_q, m_cmd_address_d;
    logic [LEN_WIDTH-1:0]  m_cmd_length_q, m_cmd_length_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]       tag_mem_q [TAG_DEPTH];
    logic [CH_W-1:0]       tag_mem_d [TAG_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  sts_orphan_q, sts_orphan_d;

    logic                  found;
    logic [CH_W-1:0]       win;
    logic                  can_load;
    logic                  cmd_hs;
    logic                  empty;
    logic [CH_W-1:0]       head;
    logic                  sts_hs;
    logic [ADDR_WIDTH-1:0] win_address;
    logic [LEN_WIDTH-1:0]  win_length;

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_cmd_valid_q   <= 1'b0;
            m_cmd_address_q <= '0;
            m_cmd_length_q  <= '0;
            rr_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            sts_orphan_q    <= 1'b0;
            for (int i = 0; i < int'(TAG_DEPTH); i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            m_cmd_valid_q   <= m_cmd_valid_d;
            m_cmd_address_q <= m_cmd_address_d;
            m_cmd_length_q  <= m_cmd_length_d;
            rr_ptr_q        <= rr_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            sts_orphan_q    <= sts_orphan_d;
            tag_mem_q       <= tag_mem_d;
        end
    end

    // Round-robin search from rr_ptr with wrap; first requester wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            if (!found && s_cmd_valid[CH_W'((32'(rr_ptr_q) + k) % NUM_CHANNELS)]) begin
                found = 1'b1;
                win   = CH_W'((32'(rr_ptr_q) + k) % NUM_CHANNELS);
            end
        end
    end

    // Winner payload mux
    always_comb begin
        win_address = '0;
        win_length  = '0;
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            if (win == CH_W'(i)) begin
                win_address = s_cmd_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_length  = s_cmd_length[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    // Status routing and next-state logic
    always_comb begin
        // Full is judged on the registered count; a same-cycle pop does not free a slot
        can_load = (!m_cmd_valid_q || m_cmd_ready) && (count_q < CNT_W'(TAG_DEPTH));
        cmd_hs   = found && can_load;
        empty    = (count_q == '0);
        head     = tag_mem_q[rd_ptr_q];

        s_cmd_ready = '0;
        if (cmd_hs) begin
            s_cmd_ready[win] = 1'b1;
        end

        m_sts_valid = '0;
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            m_sts_valid[i] = s_sts_valid && !empty && (head == CH_W'(i));
        end
        s_sts_ready = !empty && m_sts_ready[head];
        sts_hs      = s_sts_valid && s_sts_ready;

        m_cmd_valid_d   = m_cmd_valid_q && !m_cmd_ready;
        m_cmd_address_d = m_cmd_address_q;
        m_cmd_length_d  = m_cmd_length_q;
        rr_ptr_d        = rr_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        tag_mem_d       = tag_mem_q;
        sts_orphan_d    = sts_orphan_q || (s_sts_valid && empty);

        if (cmd_hs) begin
            m_cmd_valid_d       = 1'b1;
            m_cmd_address_d     = win_address;
            m_cmd_length_d      = win_length;
            rr_ptr_d            = CH_W'((32'(win) + 32'd1) % NUM_CHANNELS);
            tag_mem_d[wr_ptr_q] = win;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (sts_hs) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({cmd_hs, sts_hs})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign m_cmd_valid   = m_cmd_valid_q;
    assign m_cmd_address = m_cmd_address_q;
    assign m_cmd_length  = m_cmd_length_q;
    assign m_sts_data    = {NUM_CHANNELS{s_sts_data}};
    assign inflight      = count_q;
    assign sts_orphan    = sts_orphan_q;

endmodule

// File: tb/tb_mem_cmd_rr_arbiter.sv
// Directed bench for mem_cmd_rr_arbiter: vector table plus hand-written corner sequences.
module tb_mem_cmd_rr_arbiter;

    logic         aclk = 1'b0;
    logic         areset;
    logic [1:0]   s_cmd_valid;
    logic [1:0]   s_cmd_ready;
    logic [127:0] s_cmd_address;
    logic [63:0]  s_cmd_length;
    logic         m_cmd_valid;
    logic         m_cmd_ready;
    logic [63:0]  m_cmd_address;
    logic [31:0]  m_cmd_length;
    logic         s_sts_valid;
    logic         s_sts_ready;
    logic [7:0]   s_sts_data;
    logic [1:0]   m_sts_valid;
    logic [1:0]   m_sts_ready;
    logic [15:0]  m_sts_data;
    logic [3:0]   inflight;
    logic         sts_orphan;

    int n_tests = 0;
    int n_fail  = 0;

    mem_cmd_rr_arbiter dut (
        .aclk(aclk), .areset(areset),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_address(s_cmd_address), .s_cmd_length(s_cmd_length),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length),
        .s_sts_valid(s_sts_valid), .s_sts_ready(s_sts_ready), .s_sts_data(s_sts_data),
        .m_sts_valid(m_sts_valid), .m_sts_ready(m_sts_ready), .m_sts_data(m_sts_data),
        .inflight(inflight), .sts_orphan(sts_orphan)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [1:0]  cv;
        logic [63:0] a0;
        logic [63:0] a1;
        logic [31:0] l0;
        logic [31:0] l1;
        logic        mr;
        logic        sv;
        logic [7:0]  sd;
        logic [1:0]  msr;
        logic [1:0]  e_scr;
        logic        e_mv;
        logic [63:0] e_ma;
        logic [31:0] e_ml;
        logic [1:0]  e_msv;
        logic        e_ssr;
        logic [3:0]  e_inf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] cv, logic [63:0] a0, logic [63:0] a1,
                                logic [31:0] l0, logic [31:0] l1, logic mr, logic sv,
                                logic [7:0] sd, logic [1:0] msr, logic [1:0] e_scr,
                                logic e_mv, logic [63:0] e_ma, logic [31:0] e_ml,
                                logic [1:0] e_msv, logic e_ssr, logic [3:0] e_inf);
        vec_t v;
        v.cv = cv; v.a0 = a0; v.a1 = a1; v.l0 = l0; v.l1 = l1; v.mr = mr; v.sv = sv;
        v.sd = sd; v.msr = msr; v.e_scr = e_scr; v.e_mv = e_mv; v.e_ma = e_ma;
        v.e_ml = e_ml; v.e_msv = e_msv; v.e_ssr = e_ssr; v.e_inf = e_inf;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        s_cmd_valid   = 2'b00;
        s_cmd_address = '0;
        s_cmd_length  = '0;
        m_cmd_ready   = 1'b1;
        s_sts_valid   = 1'b0;
        s_sts_data    = 8'h00;
        m_sts_ready   = 2'b11;
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        idle_inputs();
        step();
        areset = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            vec_t v;
            v = vecs[i];
            s_cmd_valid   = v.cv;
            s_cmd_address = {v.a1, v.a0};
            s_cmd_length  = {v.l1, v.l0};
            m_cmd_ready   = v.mr;
            s_sts_valid   = v.sv;
            s_sts_data    = v.sd;
            m_sts_ready   = v.msr;
            #2;
            check($sformatf("vec%0d s_cmd_ready", i), 64'(s_cmd_ready), 64'(v.e_scr));
            check($sformatf("vec%0d m_cmd_valid", i), 64'(m_cmd_valid), 64'(v.e_mv));
            if (v.e_mv) begin
                check($sformatf("vec%0d m_cmd_address", i), m_cmd_address, v.e_ma);
                check($sformatf("vec%0d m_cmd_length", i), 64'(m_cmd_length), 64'(v.e_ml));
            end
            check($sformatf("vec%0d m_sts_valid", i), 64'(m_sts_valid), 64'(v.e_msv));
            check($sformatf("vec%0d s_sts_ready", i), 64'(s_sts_ready), 64'(v.e_ssr));
            check($sformatf("vec%0d m_sts_data", i), 64'(m_sts_data), 64'({v.sd, v.sd}));
            check($sformatf("vec%0d inflight", i), 64'(inflight), 64'(v.e_inf));
            step();
        end
    endtask

    initial begin
        // Single-channel issue and status return (vectors 0..3)
        vecs.push_back(mk(2'b01, 64'h1000, 64'h0, 32'd64, 32'd0, 1, 0, 8'h00, 2'b11,
                          2'b01, 0, 64'h0, 32'd0, 2'b00, 0, 4'd0));
        vecs.push_back(mk(2'b00, 64'h1000, 64'h0, 32'd64, 32'd0, 1, 0, 8'h00, 2'b11,
                          2'b00, 1, 64'h1000, 32'd64, 2'b00, 1, 4'd1));
        vecs.push_back(mk(2'b00, 64'h1000, 64'h0, 32'd64, 32'd0, 1, 1, 8'h80, 2'b11,
                          2'b00, 0, 64'h0, 32'd0, 2'b01, 1, 4'd1));
        vecs.push_back(mk(2'b00, 64'h1000, 64'h0, 32'd64, 32'd0, 1, 0, 8'h00, 2'b11,
                          2'b00, 0, 64'h0, 32'd0, 2'b00, 0, 4'd0));
        // Fairness from reset: grants 0,1,0,1..., then tag FIFO full (vectors 4..13)
        for (int k = 0; k < 8; k++) begin
            logic [63:0] ea;
            logic [31:0] el;
            ea = (k % 2 == 1) ? 64'hA000 : 64'hB000;
            el = (k % 2 == 1) ? 32'h10 : 32'h20;
            vecs.push_back(mk(2'b11, 64'hA000, 64'hB000, 32'h10, 32'h20, 1, 0, 8'h00, 2'b11,
                              (k % 2 == 0) ? 2'b01 : 2'b10, k != 0, ea, el, 2'b00,
                              k != 0, 4'(k)));
        end
        vecs.push_back(mk(2'b11, 64'hA000, 64'hB000, 32'h10, 32'h20, 1, 0, 8'h00, 2'b11,
                          2'b00, 1, 64'hB000, 32'h20, 2'b00, 1, 4'd8));
        vecs.push_back(mk(2'b11, 64'hA000, 64'hB000, 32'h10, 32'h20, 1, 0, 8'h00, 2'b11,
                          2'b00, 0, 64'h0, 32'd0, 2'b00, 1, 4'd8));
        // Drain: statuses routed in issue order 0,1,0,1... (vectors 14..22)
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(2'b00, 64'h0, 64'h0, 32'd0, 32'd0, 1, 1, 8'(8'h11 + k), 2'b11,
                              2'b00, 0, 64'h0, 32'd0, (k % 2 == 0) ? 2'b01 : 2'b10, 1,
                              4'(8 - k)));
        end
        vecs.push_back(mk(2'b00, 64'h0, 64'h0, 32'd0, 32'd0, 1, 0, 8'h00, 2'b11,
                          2'b00, 0, 64'h0, 32'd0, 2'b00, 0, 4'd0));

        // Reset state
        areset = 1'b1;
        idle_inputs();
        #2;
        check("rst m_cmd_valid", 64'(m_cmd_valid), 64'd0);
        check("rst m_cmd_address", m_cmd_address, 64'd0);
        check("rst m_cmd_length", 64'(m_cmd_length), 64'd0);
        check("rst inflight", 64'(inflight), 64'd0);
        check("rst sts_orphan", 64'(sts_orphan), 64'd0);
        step();
        step();
        areset = 1'b0;

        run_vecs(0, 3);
        pulse_reset();
        run_vecs(4, 22);

        // Command backpressure: held output stable, no grant, no extra tag
        s_cmd_valid   = 2'b01;
        s_cmd_address = {64'h0, 64'hC000};
        s_cmd_length  = {32'h0, 32'h33};
        m_cmd_ready   = 1'b0;
        #2;
        check("bp first grant", 64'(s_cmd_ready), 64'b01);
        step();
        for (int k = 0; k < 5; k++) begin
            s_cmd_valid   = 2'b11;
            s_cmd_address = {64'h5555, 64'hDEAD};
            s_cmd_length  = {32'h77, 32'h99};
            #2;
            check($sformatf("bp%0d s_cmd_ready", k), 64'(s_cmd_ready), 64'b00);
            check($sformatf("bp%0d m_cmd_valid", k), 64'(m_cmd_valid), 64'd1);
            check($sformatf("bp%0d m_cmd_address", k), m_cmd_address, 64'hC000);
            check($sformatf("bp%0d m_cmd_length", k), 64'(m_cmd_length), 64'h33);
            check($sformatf("bp%0d inflight", k), 64'(inflight), 64'd1);
            step();
        end
        s_cmd_valid = 2'b00;
        m_cmd_ready = 1'b1;
        step();
        #2;
        check("bp release m_cmd_valid", 64'(m_cmd_valid), 64'd0);
        check("bp release inflight", 64'(inflight), 64'd1);

        // Status backpressure on the head channel, then orphan status
        s_sts_valid = 1'b1;
        s_sts_data  = 8'h55;
        m_sts_ready = 2'b10;
        #2;
        check("sbp s_sts_ready", 64'(s_sts_ready), 64'd0);
        check("sbp m_sts_valid", 64'(m_sts_valid), 64'b01);
        step();
        #2;
        check("sbp hold inflight", 64'(inflight), 64'd1);
        check("sbp hold s_sts_ready", 64'(s_sts_ready), 64'd0);
        m_sts_ready = 2'b11;
        #1;
        check("sbp accept s_sts_ready", 64'(s_sts_ready), 64'd1);
        step();
        s_sts_valid = 1'b0;
        #2;
        check("sbp popped inflight", 64'(inflight), 64'd0);
        check("orphan before", 64'(sts_orphan), 64'd0);
        s_sts_valid = 1'b1;
        #1;
        check("orphan s_sts_ready", 64'(s_sts_ready), 64'd0);
        check("orphan m_sts_valid", 64'(m_sts_valid), 64'b00);
        step();
        s_sts_valid = 1'b0;
        #2;
        check("orphan set", 64'(sts_orphan), 64'd1);
        step();
        check("orphan sticky", 64'(sts_orphan), 64'd1);

        // Tag full with ch1 only; a pop frees a slot only on the following cycle
        for (int k = 0; k < 8; k++) begin
            s_cmd_valid   = 2'b10;
            s_cmd_address = {64'(64'h2000 + k), 64'h0};
            #2;
            check($sformatf("full issue%0d s_cmd_ready", k), 64'(s_cmd_ready), 64'b10);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            #2;
            check($sformatf("full%0d s_cmd_ready", k), 64'(s_cmd_ready), 64'b00);
            check($sformatf("full%0d inflight", k), 64'(inflight), 64'd8);
            step();
        end
        s_sts_valid = 1'b1;
        s_sts_data  = 8'h66;
        #2;
        check("full pop s_cmd_ready", 64'(s_cmd_ready), 64'b00);
        check("full pop m_sts_valid", 64'(m_sts_valid), 64'b10);
        check("full pop s_sts_ready", 64'(s_sts_ready), 64'd1);
        step();
        s_sts_valid = 1'b0;
        #2;
        check("full after pop inflight", 64'(inflight), 64'd7);
        check("full after pop s_cmd_ready", 64'(s_cmd_ready), 64'b10);
        step();
        #2;
        check("full refill inflight", 64'(inflight), 64'd8);
        check("full refill s_cmd_ready", 64'(s_cmd_ready), 64'b00);

        // Async reset mid-burst with three commands outstanding
        check("orphan before reset", 64'(sts_orphan), 64'd1);
        pulse_reset();
        #2;
        check("reset clears orphan", 64'(sts_orphan), 64'd0);
        for (int k = 0; k < 3; k++) begin
            s_cmd_valid   = 2'b11;
            s_cmd_address = {64'h3100, 64'h3000};
            s_cmd_length  = {32'h8, 32'h4};
            #1;
            check($sformatf("burst%0d s_cmd_ready", k), 64'(s_cmd_ready),
                  (k % 2 == 0) ? 64'b01 : 64'b10);
            step();
        end
        #2;
        check("burst inflight", 64'(inflight), 64'd3);
        check("burst m_cmd_valid", 64'(m_cmd_valid), 64'd1);
        areset = 1'b1;
        #1;
        check("async m_cmd_valid", 64'(m_cmd_valid), 64'd0);
        check("async m_cmd_address", m_cmd_address, 64'd0);
        check("async m_cmd_length", 64'(m_cmd_length), 64'd0);
        check("async inflight", 64'(inflight), 64'd0);
        check("async m_sts_valid", 64'(m_sts_valid), 64'b00);
        step();
        areset = 1'b0;
        s_cmd_valid = 2'b11;
        #2;
        check("post reset grant ch0", 64'(s_cmd_ready), 64'b01);
        s_cmd_valid = 2'b00;
        s_sts_valid = 1'b1;
        step();
        s_sts_valid = 1'b0;
        #2;
        check("post reset orphan", 64'(sts_orphan), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
